// File: rtl/exec_trace_buffer.sv
// Execution-trace capture: taps the retire stream into a circular buffer,
// stops on a programmable trigger plus post window, then replays oldest-first.
module exec_trace_buffer #(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 16,
    parameter int POST_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            arm,
    input  logic            clear,
    input  logic [1:0]      trig_mode,
    input  logic [XLEN-1:0] trig_pc,
    input  logic [4:0]      trig_reg,
    input  logic            sample_valid,
    input  logic [XLEN-1:0] pc,
    input  logic [31:0]     instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_pc,
    output logic [31:0]     rd_instr,
    output logic            rd_wb_en,
    output logic [4:0]      rd_wb_rd,
    output logic [XLEN-1:0] rd_wb_data,
    output logic [1:0]      state,
    output logic            triggered
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   post_cnt_r;
    logic [AW:0]     fill_r;
    logic [AW:0]     rd_left_r;
    logic            rd_valid_r;
    logic            triggered_r;

    logic [XLEN-1:0] mem_pc_r      [DEPTH];
    logic [31:0]     mem_instr_r   [DEPTH];
    logic            mem_wb_en_r   [DEPTH];
    logic [4:0]      mem_wb_rd_r   [DEPTH];
    logic [XLEN-1:0] mem_wb_data_r [DEPTH];

    logic            trig_hit_s;
    logic            store_s;
    logic            rd_load_s;
    logic [AW-1:0]   first_idx_s;
    logic [AW-1:0]   rd_idx_s;

    // Trigger condition evaluated on the current retire sample
    always_comb begin
        trig_hit_s = 1'b0;
        case (trig_mode)
            2'd0:    trig_hit_s = (pc == trig_pc);
            2'd1:    trig_hit_s = wb_en && (wb_rd == trig_reg) && (wb_rd != 5'd0);
            2'd2:    trig_hit_s = 1'b1;
            2'd3:    trig_hit_s = 1'b0;
            default: trig_hit_s = 1'b0;
        endcase
    end

    // Store enable, readout index and readout load strobe; clear suppresses all
    always_comb begin
        store_s     = sample_valid && !clear && ((state_r == ST_ARMED) || (state_r == ST_POST));
        first_idx_s = wr_ptr_r - fill_r[AW-1:0];
        rd_idx_s    = rd_valid_r ? rd_ptr_r : first_idx_s;
        rd_load_s   = (state_r == ST_DONE) && !clear &&
                      (!rd_valid_r || (rd_ready && (rd_left_r != {(AW+1){1'b0}})));
    end

    // Trace storage: contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (store_s) begin
            mem_pc_r[wr_ptr_r]      <= pc;
            mem_instr_r[wr_ptr_r]   <= instr;
            mem_wb_en_r[wr_ptr_r]   <= wb_en;
            mem_wb_rd_r[wr_ptr_r]   <= wb_rd;
            mem_wb_data_r[wr_ptr_r] <= wb_data;
        end
    end

    // Capture/readout control FSM with pointers and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            post_cnt_r  <= {AW{1'b0}};
            fill_r      <= {(AW+1){1'b0}};
            rd_left_r   <= {(AW+1){1'b0}};
            rd_valid_r  <= 1'b0;
            triggered_r <= 1'b0;
        end else if (clear) begin
            state_r    <= ST_IDLE;
            rd_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm) begin
                        wr_ptr_r    <= {AW{1'b0}};
                        fill_r      <= {(AW+1){1'b0}};
                        post_cnt_r  <= {AW{1'b0}};
                        triggered_r <= 1'b0;
                        state_r     <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (sample_valid) begin
                        wr_ptr_r <= wr_ptr_r + AW'(1);
                        if (fill_r != (AW+1)'(DEPTH)) fill_r <= fill_r + (AW+1)'(1);
                        if (trig_hit_s) begin
                            triggered_r <= 1'b1;
                            post_cnt_r  <= AW'(POST_DEPTH);
                            state_r     <= (POST_DEPTH == 0) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (sample_valid) begin
                        wr_ptr_r   <= wr_ptr_r + AW'(1);
                        if (fill_r != (AW+1)'(DEPTH)) fill_r <= fill_r + (AW+1)'(1);
                        post_cnt_r <= post_cnt_r - AW'(1);
                        if (post_cnt_r == AW'(1)) state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First cycle in DONE presents the oldest retained entry
                    if (!rd_valid_r) begin
                        rd_valid_r <= 1'b1;
                        rd_ptr_r   <= first_idx_s + AW'(1);
                        rd_left_r  <= fill_r - (AW+1)'(1);
                    end else if (rd_ready) begin
                        if (rd_left_r == {(AW+1){1'b0}}) begin
                            rd_valid_r <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            rd_ptr_r  <= rd_ptr_r + AW'(1);
                            rd_left_r <= rd_left_r - (AW+1)'(1);
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Registered readout entry, held stable while the consumer stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pc      <= {XLEN{1'b0}};
            rd_instr   <= 32'd0;
            rd_wb_en   <= 1'b0;
            rd_wb_rd   <= 5'd0;
            rd_wb_data <= {XLEN{1'b0}};
        end else if (rd_load_s) begin
            rd_pc      <= mem_pc_r[rd_idx_s];
            rd_instr   <= mem_instr_r[rd_idx_s];
            rd_wb_en   <= mem_wb_en_r[rd_idx_s];
            rd_wb_rd   <= mem_wb_rd_r[rd_idx_s];
            rd_wb_data <= mem_wb_data_r[rd_idx_s];
        end
    end

    assign rd_valid  = rd_valid_r;
    assign state     = state_r;
    assign triggered = triggered_r;

endmodule

// File: doc/exec_trace_buffer.md
# exec_trace_buffer

Parametrised execution-trace capture block for the RISC-V core. It taps the per-instruction retire stream (PC, instruction, writeback register, writeback data) into a circular buffer and stops on a programmable trigger with a configurable post-trigger window. It then replays the captured window oldest-first over a valid/ready port. It sits beside the core as an on-chip replacement for per-cycle state dumping and is synthesisable.

## Interface
- `XLEN`, 64, datapath and PC width.
- `DEPTH`, 16, number of trace entries; power of two, ≥4.
- `POST_DEPTH`, 8, samples stored after the trigger sample; 0..DEPTH-1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `arm`  in  1  pulse; IDLE→ARMED.
- `clear`  in  1  abort to IDLE from any state.
- `trig_mode`  in  2  0=PC match, 1=writeback to `trig_reg`, 2=trigger on first sample, 3=never.
- `trig_pc`  in  XLEN  PC compare value.
- `trig_reg`  in  5  register index for mode 1.
- `sample_valid`  in  1  an instruction retires this cycle.
- `pc`  in  XLEN  retiring PC.
- `instr`  in  32  retiring instruction.
- `wb_en`  in  1  retiring instruction writes a register.
- `wb_rd`  in  5  destination register.
- `wb_data`  in  XLEN  writeback value.
- `rd_ready`  in  1  consumer accepts the current entry.
- `rd_valid`  out  1  readout entry valid.
- `rd_pc`, `rd_instr`, `rd_wb_en`, `rd_wb_rd`, `rd_wb_data`  out  XLEN/32/1/5/XLEN  readout entry.
- `state`  out  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE.
- `triggered`  out  1  trigger has fired since the last arm.

## Operation
- IDLE: nothing is stored. On `arm`, the block clears the write pointer, fill count and `triggered`, then moves to ARMED.
- ARMED: every `sample_valid` cycle writes the entry at `wr_ptr` and increments `wr_ptr` mod DEPTH. The fill count increments and saturates at DEPTH.
- Trigger is evaluated on the same sample:
  - Mode 0: `pc==trig_pc`.
  - Mode 1: `wb_en && wb_rd==trig_reg && wb_rd!=0`.
  - Mode 2: any sample.
  - Mode 3: never fires.
- On a trigger sample: the entry is stored, `triggered`←1, `post_cnt`←POST_DEPTH. State goes to POST, or straight to DONE if POST_DEPTH==0.
- POST: each stored sample decrements `post_cnt`. The sample that takes it to 0 is stored, then state goes to DONE.
- DONE: no further capture.
  - Retained count N = min(fill, DEPTH).
  - Read pointer starts at (`wr_ptr`−N) mod DEPTH.
  - Entries are presented oldest first; each `rd_valid && rd_ready` edge advances.
  - After the N-th transfer: `rd_valid`←0, state→IDLE. `triggered` stays 1 until the next `arm`.
- `arm` while ARMED, POST or DONE is ignored.
- `clear` wins over every other event in the same cycle, including trigger, store and transfer. It takes the block to IDLE and drops `rd_valid`.
- Storage contents are not reset. Only pointers, counters and outputs are.

## Timing
- Reset values while `reset_n` is low, asynchronously: `state`=0, `rd_valid`=0, `triggered`=0, all `rd_*` data=0, pointers and counters=0.
- Capture is one cycle: a sample at edge k is in storage after edge k.
- Readout outputs are registered. `rd_valid` rises on the first edge after entering DONE, so the first entry appears 1 cycle after the DONE transition.
- A transfer on edge k presents the next entry on the same edge, giving one entry per cycle at full throughput.
- With `rd_ready` low, `rd_valid` and all `rd_*` fields hold stable.
- Wrap-around: once more than DEPTH samples are captured, the oldest entries are overwritten and N=DEPTH.
- Reset mid-POST or mid-readout aborts immediately. `arm` after release operates normally.

## Test plan
1. DEPTH=8, POST_DEPTH=3, mode 0, `trig_pc`=0x28; stream pc=0x00,0x04,… one per cycle → DONE after pc=0x34. Readout gives 8 beats, pc 0x18..0x34 ascending by 4, then `state`=0 and `triggered`=1.
2. Same configuration with `trig_pc`=0x04 (early trigger, no wrap) → 5 beats: pc 0x00, 0x04, 0x08, 0x0C, 0x10.
3. Mode 1, `trig_reg`=21. Send a write to x0, then `wb_en`=0 with `wb_rd`=21, then a write to x21 with data 0xB → only the third sample triggers. The corresponding readout beat has `rd_wb_rd`=21, `rd_wb_data`=0xB.
4. Backpressure: hold `rd_ready` low 3 cycles mid-readout → `rd_pc` is unchanged for all 3 cycles, and no entry is lost or duplicated.
5. Assert `reset_n` low during POST → immediately `state`=0, `rd_valid`=0, `triggered`=0. Re-arm, then mode 2 with POST_DEPTH=0 → DONE after 1 sample and a 1-beat readout.
6. `clear` asserted together with a trigger sample in ARMED → IDLE, `triggered`=0, `rd_valid` never rises.
